// File: rtl/branch_outcome_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_outcome_tracker_if
// Brief    : Fetch/execute/predictor-facing signal bundle of the tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_outcome_tracker_if #(
    parameter int LOW_ADDR_WIDTH = 8,
    parameter int PTR_WIDTH      = 2
);
    logic                      push_valid;
    logic [LOW_ADDR_WIDTH-1:0] push_addr;
    logic                      push_predict;
    logic                      push_ready;
    logic                      resolve_valid;
    logic                      resolve_taken;
    logic                      flush;
    logic                      renew_valid;
    logic                      last_predict;
    logic [LOW_ADDR_WIDTH-1:0] renew_addr;
    logic                      renew_result;
    logic                      mispredict;
    logic [PTR_WIDTH:0]        count;
    logic                      underflow_err;

    modport master (
        output push_valid, push_addr, push_predict, resolve_valid, resolve_taken, flush,
        input  push_ready, renew_valid, last_predict, renew_addr, renew_result,
               mispredict, count, underflow_err
    );

    modport slave (
        input  push_valid, push_addr, push_predict, resolve_valid, resolve_taken, flush,
        output push_ready, renew_valid, last_predict, renew_addr, renew_result,
               mispredict, count, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/branch_outcome_tracker.sv
`default_nettype none
// ============================================================================
// Module   : branch_outcome_tracker
// Brief    : In-order FIFO of in-flight branch predictions; retires the head on
//            resolve and reports the outcome to the predictor one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module branch_outcome_tracker #(
    parameter int LOW_ADDR_WIDTH = 8,
    parameter int DEPTH          = 4,
    parameter int PTR_WIDTH      = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    branch_outcome_tracker_if.slave bus
);

    localparam logic [PTR_WIDTH:0]   c_FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   c_CNT_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] c_PTR_ONE    = PTR_WIDTH'(1);

    // Each entry is {addr, predicted direction}
    logic [LOW_ADDR_WIDTH:0]   r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]      r_wr_ptr;
    logic [PTR_WIDTH-1:0]      r_rd_ptr;
    logic [PTR_WIDTH:0]        r_count;
    logic                      r_renew_valid;
    logic                      r_last_predict;
    logic [LOW_ADDR_WIDTH-1:0] r_renew_addr;
    logic                      r_renew_result;
    logic                      r_mispredict;
    logic                      r_underflow_err;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_squash;
    logic                      w_clear;
    logic                      w_push;
    logic [LOW_ADDR_WIDTH-1:0] w_head_addr;
    logic                      w_head_predict;

    assign w_full         = (r_count == c_FULL_COUNT);
    assign w_empty        = (r_count == '0);
    assign w_head_addr    = r_mem[r_rd_ptr][LOW_ADDR_WIDTH:1];
    assign w_head_predict = r_mem[r_rd_ptr][0];
    assign w_pop          = bus.resolve_valid & ~w_empty;
    // A wrong head prediction makes every younger entry wrong-path
    assign w_squash       = w_pop & (w_head_predict != bus.resolve_taken);
    assign w_clear        = w_squash | bus.flush;
    assign w_push         = bus.push_valid & ~w_full & ~w_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.push_addr, bus.push_predict};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Renew fields hold their last values between retirements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_renew_valid   <= 1'b0;
            r_last_predict  <= 1'b0;
            r_renew_addr    <= '0;
            r_renew_result  <= 1'b0;
            r_mispredict    <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_renew_valid <= w_pop;
            r_mispredict  <= w_squash;
            if (w_pop) begin
                r_last_predict <= w_head_predict;
                r_renew_addr   <= w_head_addr;
                r_renew_result <= bus.resolve_taken;
            end
            if (bus.resolve_valid & w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign bus.push_ready    = ~w_full;
    assign bus.renew_valid   = r_renew_valid;
    assign bus.last_predict  = r_last_predict;
    assign bus.renew_addr    = r_renew_addr;
    assign bus.renew_result  = r_renew_result;
    assign bus.mispredict    = r_mispredict;
    assign bus.count         = r_count;
    assign bus.underflow_err = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_outcome_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_outcome_tracker
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_outcome_tracker;

    typedef struct packed {
        logic [7:0] addr;
        logic       pred;
        logic       res;
    } renew_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_outcome_tracker_if #(.LOW_ADDR_WIDTH(8), .PTR_WIDTH(2)) bus ();

    branch_outcome_tracker #(
        .LOW_ADDR_WIDTH (8),
        .DEPTH          (4),
        .PTR_WIDTH      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [8:0] model_q [$];
    renew_t     exp_q   [$];
    logic       exp_underflow;
    logic [7:0] last_addr;
    logic       last_pred;
    logic       last_res;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        renew_t e;
        if (bus.renew_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("renew_spurious", 32'(bus.renew_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("renew_addr", 32'(bus.renew_addr), 32'(e.addr));
                check("last_predict", 32'(bus.last_predict), 32'(e.pred));
                check("renew_result", 32'(bus.renew_result), 32'(e.res));
                check("mispredict", 32'(bus.mispredict), 32'(e.pred ^ e.res));
                last_addr = e.addr;
                last_pred = e.pred;
                last_res  = e.res;
            end
        end else begin
            check("renew_missing", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            check("mispredict_idle", 32'(bus.mispredict), 32'd0);
            check("hold_addr", 32'(bus.renew_addr), 32'(last_addr));
            check("hold_predict", 32'(bus.last_predict), 32'(last_pred));
            check("hold_result", 32'(bus.renew_result), 32'(last_res));
        end
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("push_ready", 32'(bus.push_ready), 32'(model_q.size() != 4));
        check("underflow_err", 32'(bus.underflow_err), 32'(exp_underflow));
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.push_valid    = 1'b0;
        bus.push_addr     = 8'h00;
        bus.push_predict  = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
        model_q.delete();
        exp_q.delete();
        exp_underflow = 1'b0;
        last_addr     = 8'h00;
        last_pred     = 1'b0;
        last_res      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
    endtask

    task automatic cycle(input logic pv, input logic [7:0] pa, input logic pp,
                         input logic rv, input logic rt, input logic fl);
        logic       full;
        logic       pop;
        logic       squash;
        logic       push_acc;
        logic [8:0] head;
        renew_t     e;
        bus.push_valid    = pv;
        bus.push_addr     = pa;
        bus.push_predict  = pp;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        bus.flush         = fl;
        full     = (model_q.size() == 4);
        pop      = rv && (model_q.size() > 0);
        head     = (model_q.size() > 0) ? model_q[0] : 9'h000;
        squash   = pop && (head[0] != rt);
        push_acc = pv && !full && !squash && !fl;
        @(posedge clk);
        #1;
        if (rv && model_q.size() == 0) exp_underflow = 1'b1;
        if (pop) begin
            e.addr = head[8:1];
            e.pred = head[0];
            e.res  = rt;
            exp_q.push_back(e);
            void'(model_q.pop_front());
        end
        if (squash || fl) model_q.delete();
        if (push_acc) model_q.push_back({pa, pp});
        bus.push_valid    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.flush         = 1'b0;
        check_state();
    endtask

    initial begin
        // Reset
        do_reset();

        // Basic push/resolve
        cycle(1, 8'h12, 1, 0, 0, 0);
        cycle(1, 8'h34, 0, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        check("basic_renew_addr", 32'(bus.renew_addr), 32'h12);
        cycle(0, 8'h00, 0, 1, 0, 0);

        // Fill, overflow drop, wrap
        for (int i = 1; i <= 5; i++) cycle(1, 8'(i), 1, 0, 0, 0);
        check("full_ready", 32'(bus.push_ready), 32'd0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        cycle(1, 8'h06, 1, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        check("wrap_renew_addr", 32'(bus.renew_addr), 32'h06);
        cycle(0, 8'h00, 0, 0, 0, 0);

        // Squash drops younger entries and the concurrent push
        cycle(1, 8'hA0, 1, 0, 0, 0);
        cycle(1, 8'hB1, 0, 0, 0, 0);
        cycle(1, 8'hB2, 1, 0, 0, 0);
        cycle(1, 8'hC3, 1, 1, 0, 0);
        check("squash_mispredict", 32'(bus.mispredict), 32'd1);
        check("squash_count", 32'(bus.count), 32'd0);

        // Underflow is sticky; concurrent push accepted
        cycle(1, 8'h55, 0, 1, 1, 0);
        check("underflow_set", 32'(bus.underflow_err), 32'd1);
        cycle(1, 8'h56, 1, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 1, 0);
        cycle(0, 8'h00, 0, 0, 0, 0);

        // Flush with an older resolve retiring the head
        cycle(1, 8'h66, 1, 0, 0, 0);
        cycle(1, 8'h67, 0, 0, 0, 0);
        cycle(1, 8'h68, 0, 1, 1, 1);
        check("flush_renew_addr", 32'(bus.renew_addr), 32'h66);
        cycle(1, 8'h77, 0, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0, 0);
        check("after_flush_addr", 32'(bus.renew_addr), 32'h77);

        // Reset mid-operation, underflow cleared
        cycle(1, 8'h80, 1, 0, 0, 0);
        cycle(1, 8'h81, 1, 0, 0, 0);
        do_reset();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom()), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        cycle(0, 8'h00, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
